// File: rtl/exec_cfg_pkg.sv
// Shared types and constants for the execution-lane reconfiguration controller.
package exec_cfg_pkg;

   localparam int NUM_LANES = 4;

   typedef logic [NUM_LANES-1:0] lane_mask_t;

   // Lane 0 can never be switched off; the accepted request mask always has bit 0 set.
   localparam logic LANE0_ALWAYS_ON = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DRAIN  = 3'd1,
      APPLY  = 3'd2,
      SETTLE = 3'd3,
      ACK    = 3'd4
   } cfg_state_e;

endpackage

// File: rtl/lane_inflight_counter.sv
// Tracks how many instructions one execution lane currently holds between
// register-read and writeback. Saturates at both ends and flags the violation.
module lane_inflight_counter #(
   parameter int PIPE_DEPTH = 3,
   parameter int CNT_W      = $clog2(PIPE_DEPTH + 2)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             dec,
   input  logic             flush,
   output logic [CNT_W-1:0] count,
   output logic             err
);

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PIPE_DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] count_r;

   // Underflow/overflow detection for this cycle; a flush overrides both.
   always_comb begin
      err = 1'b0;
      if (flush) begin
         err = 1'b0;
      end else begin
         err = (dec && !inc && (count_r == CNT_ZERO)) ||
               (inc && !dec && (count_r == CNT_MAX));
      end
   end

   // Saturating up/down count; simultaneous inc and dec cancel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= CNT_ZERO;
      end else if (flush) begin
         count_r <= CNT_ZERO;
      end else if (inc && !dec && (count_r != CNT_MAX)) begin
         count_r <= count_r + CNT_ONE;
      end else if (dec && !inc && (count_r != CNT_ZERO)) begin
         count_r <= count_r - CNT_ONE;
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/exec_lane_config_ctrl.sv
// Sequences a lane-mask change: stall issue, drain every lane, apply the new
// mask to the pipes/clock gaters, wait a settle interval, then acknowledge.
module exec_lane_config_ctrl
   import exec_cfg_pkg::*;
#(
   parameter int ISSUE_WIDTH   = 4,
   parameter int PIPE_DEPTH    = 3,
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = $clog2(PIPE_DEPTH + 2)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush_i,
   input  logic                   cfgReq_i,
   input  logic [ISSUE_WIDTH-1:0] cfgLaneMask_i,
   input  logic [ISSUE_WIDTH-1:0] issueValid_i,
   input  logic [ISSUE_WIDTH-1:0] wbValid_i,
   output logic [ISSUE_WIDTH-1:0] laneActive_o,
   output logic [ISSUE_WIDTH-1:0] laneIssueEn_o,
   output logic                   issueStall_o,
   output logic                   cfgBusy_o,
   output logic                   cfgAck_o,
   output logic                   protocolErr_o
);

   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [SET_W-1:0] SET_ZERO = {SET_W{1'b0}};
   localparam logic [SET_W-1:0] SET_ONE  = SET_W'(1);
   localparam logic [ISSUE_WIDTH-1:0] ALL_ON = {ISSUE_WIDTH{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   cfg_state_e             state_r;
   logic [ISSUE_WIDTH-1:0] new_mask_r;
   logic [ISSUE_WIDTH-1:0] lane_active_r;
   logic [SET_W-1:0]       settle_r;
   logic                   stall_r;
   logic                   ack_r;
   logic                   err_r;

   logic [ISSUE_WIDTH-1:0] req_mask_s;
   logic [CNT_W-1:0]       lane_cnt_s [ISSUE_WIDTH];
   logic [ISSUE_WIDTH-1:0] lane_err_s;
   logic [ISSUE_WIDTH-1:0] lane_next_zero_s;
   logic                   all_zero_s;
   logic                   issue_err_s;

   for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_lane
      lane_inflight_counter #(
         .PIPE_DEPTH (PIPE_DEPTH),
         .CNT_W      (CNT_W)
      ) u_cnt (
         .clk   (clk),
         .rst_n (reset),
         .inc   (issueValid_i[g]),
         .dec   (wbValid_i[g]),
         .flush (flush_i),
         .count (lane_cnt_s[g]),
         .err   (lane_err_s[g])
      );
   end

   // Requested mask with lane 0 forced on.
   always_comb begin
      req_mask_s    = cfgLaneMask_i;
      req_mask_s[0] = cfgLaneMask_i[0] | LANE0_ALWAYS_ON;
   end

   // Predict whether each lane counter is zero after this edge, so drain can
   // finish in the same cycle as the last writeback or a flush.
   always_comb begin
      lane_next_zero_s = {ISSUE_WIDTH{1'b0}};
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
         if (flush_i) begin
            lane_next_zero_s[i] = 1'b1;
         end else begin
            lane_next_zero_s[i] =
               ((lane_cnt_s[i] == CNT_ZERO) && !(issueValid_i[i] && !wbValid_i[i])) ||
               ((lane_cnt_s[i] == CNT_ONE) && wbValid_i[i] && !issueValid_i[i]);
         end
      end
   end

   assign all_zero_s  = &lane_next_zero_s;
   assign issue_err_s = (|(issueValid_i & ~lane_active_r)) || (stall_r && (|issueValid_i));

   // Configuration FSM with its registered stall/ack outputs and mask registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r       <= IDLE;
         new_mask_r    <= ALL_ON;
         lane_active_r <= ALL_ON;
         settle_r      <= SET_ZERO;
         stall_r       <= 1'b0;
         ack_r         <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (cfgReq_i) begin
                  new_mask_r <= req_mask_s;
                  stall_r    <= 1'b1;
                  if (req_mask_s == lane_active_r) begin
                     state_r <= ACK;
                     ack_r   <= 1'b1;
                  end else begin
                     state_r <= DRAIN;
                     ack_r   <= 1'b0;
                  end
               end else begin
                  stall_r <= 1'b0;
                  ack_r   <= 1'b0;
               end
            end
            DRAIN: begin
               stall_r <= 1'b1;
               ack_r   <= 1'b0;
               if (all_zero_s) begin
                  state_r <= APPLY;
               end else begin
                  state_r <= DRAIN;
               end
            end
            APPLY: begin
               lane_active_r <= new_mask_r;
               settle_r      <= SET_LOAD;
               state_r       <= SETTLE;
               stall_r       <= 1'b1;
               ack_r         <= 1'b0;
            end
            SETTLE: begin
               stall_r <= 1'b1;
               if (settle_r == SET_ZERO) begin
                  state_r <= ACK;
                  ack_r   <= 1'b1;
               end else begin
                  settle_r <= settle_r - SET_ONE;
                  ack_r    <= 1'b0;
               end
            end
            ACK: begin
               state_r <= IDLE;
               stall_r <= 1'b0;
               ack_r   <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               stall_r <= 1'b0;
               ack_r   <= 1'b0;
            end
         endcase
      end
   end

   // Sticky protocol error: counter saturation or issue into a disabled/stalled lane.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_r <= 1'b0;
      end else if ((|lane_err_s) || issue_err_s) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end

   assign laneActive_o  = lane_active_r;
   assign laneIssueEn_o = lane_active_r & ~{ISSUE_WIDTH{stall_r}};
   assign issueStall_o  = stall_r;
   assign cfgBusy_o     = stall_r;
   assign cfgAck_o      = ack_r;
   assign protocolErr_o = err_r;

endmodule

// File: tb/tb_exec_lane_config_ctrl.sv
// Directed self-checking bench for exec_lane_config_ctrl.
module tb_exec_lane_config_ctrl;
   import exec_cfg_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       flush_i = 1'b0;
   logic       cfgReq_i = 1'b0;
   lane_mask_t cfgLaneMask_i = 4'b0000;
   lane_mask_t issueValid_i = 4'b0000;
   lane_mask_t wbValid_i = 4'b0000;
   lane_mask_t laneActive_o;
   lane_mask_t laneIssueEn_o;
   logic       issueStall_o;
   logic       cfgBusy_o;
   logic       cfgAck_o;
   logic       protocolErr_o;

   int checks_cnt = 0;
   int errors_cnt = 0;

   exec_lane_config_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .flush_i       (flush_i),
      .cfgReq_i      (cfgReq_i),
      .cfgLaneMask_i (cfgLaneMask_i),
      .issueValid_i  (issueValid_i),
      .wbValid_i     (wbValid_i),
      .laneActive_o  (laneActive_o),
      .laneIssueEn_o (laneIssueEn_o),
      .issueStall_o  (issueStall_o),
      .cfgBusy_o     (cfgBusy_o),
      .cfgAck_o      (cfgAck_o),
      .protocolErr_o (protocolErr_o)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock and sample 1 time unit after the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset
      #12;
      reset = 1'b1;
      tick();
      check_eq("rst_active", 32'(laneActive_o), 32'h0000_000F);
      check_eq("rst_issue_en", 32'(laneIssueEn_o), 32'h0000_000F);
      check_eq("rst_stall", 32'(issueStall_o), 32'h0);
      check_eq("rst_busy", 32'(cfgBusy_o), 32'h0);
      check_eq("rst_ack", 32'(cfgAck_o), 32'h0);
      check_eq("rst_err", 32'(protocolErr_o), 32'h0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check_eq("idle_quiet", {26'h0, cfgAck_o, issueStall_o, laneActive_o},
                  {26'h0, 1'b0, 1'b0, 4'b1111});
      end

      // Drain wait: lane 2 issue at T, request 0011 at T, writeback at T+3
      issueValid_i = 4'b0100; cfgReq_i = 1'b1; cfgLaneMask_i = 4'b0011;
      tick();                                            // T+1
      issueValid_i = 4'b0000; cfgReq_i = 1'b0;
      check_eq("dw_stall_t1", 32'(issueStall_o), 32'h1);
      check_eq("dw_busy_t1", 32'(cfgBusy_o), 32'h1);
      check_eq("dw_issue_en_t1", 32'(laneIssueEn_o), 32'h0);
      tick();                                            // T+2
      tick();                                            // T+3
      check_eq("dw_active_t3", 32'(laneActive_o), 32'h0000_000F);
      wbValid_i = 4'b0100;
      tick();                                            // T+4 (APPLY)
      wbValid_i = 4'b0000;
      check_eq("dw_active_t4", 32'(laneActive_o), 32'h0000_000F);
      tick();                                            // T+5
      check_eq("dw_active_t5", 32'(laneActive_o), 32'h0000_0003);
      tick();                                            // T+6
      check_eq("dw_ack_t6", 32'(cfgAck_o), 32'h0);
      tick();                                            // T+7
      check_eq("dw_ack_t7", 32'(cfgAck_o), 32'h1);
      tick();                                            // T+8
      check_eq("dw_ack_t8", 32'(cfgAck_o), 32'h0);
      check_eq("dw_stall_t8", 32'(issueStall_o), 32'h0);
      check_eq("dw_issue_en_t8", 32'(laneIssueEn_o), 32'h0000_0003);
      check_eq("dw_err", 32'(protocolErr_o), 32'h0);

      // Flush during drain: lane 1 count = 2, request 1111, flush at T+2
      issueValid_i = 4'b0010;
      tick();
      cfgReq_i = 1'b1; cfgLaneMask_i = 4'b1111;          // T, second lane-1 issue
      tick();                                            // T+1
      issueValid_i = 4'b0000; cfgReq_i = 1'b0;
      check_eq("fl_stall_t1", 32'(issueStall_o), 32'h1);
      tick();                                            // T+2
      flush_i = 1'b1;
      tick();                                            // T+3 (APPLY)
      flush_i = 1'b0;
      check_eq("fl_active_t3", 32'(laneActive_o), 32'h0000_0003);
      tick();                                            // T+4
      check_eq("fl_active_t4", 32'(laneActive_o), 32'h0000_000F);
      tick();                                            // T+5
      check_eq("fl_ack_t5", 32'(cfgAck_o), 32'h0);
      tick();                                            // T+6
      check_eq("fl_ack_t6", 32'(cfgAck_o), 32'h1);
      tick();                                            // T+7
      check_eq("fl_stall_t7", 32'(issueStall_o), 32'h0);
      check_eq("fl_err", 32'(protocolErr_o), 32'h0);

      // Same mask after lane-0 forcing: 1110 -> 1111 equals active
      cfgReq_i = 1'b1; cfgLaneMask_i = 4'b1110;
      tick();                                            // T+1
      cfgReq_i = 1'b0;
      check_eq("sm_ack_t1", 32'(cfgAck_o), 32'h1);
      check_eq("sm_stall_t1", 32'(issueStall_o), 32'h1);
      check_eq("sm_active_t1", 32'(laneActive_o), 32'h0000_000F);
      tick();                                            // T+2
      check_eq("sm_ack_t2", 32'(cfgAck_o), 32'h0);
      check_eq("sm_stall_t2", 32'(issueStall_o), 32'h0);
      check_eq("sm_active_t2", 32'(laneActive_o), 32'h0000_000F);

      // Underflow on lane 3 sets a sticky error
      wbValid_i = 4'b1000;
      tick();
      wbValid_i = 4'b0000;
      check_eq("uf_err_set", 32'(protocolErr_o), 32'h1);
      tick();
      tick();
      check_eq("uf_err_sticky", 32'(protocolErr_o), 32'h1);

      // Reset asserted in SETTLE aborts the sequence
      cfgReq_i = 1'b1; cfgLaneMask_i = 4'b0001;
      tick();                                            // T+1
      cfgReq_i = 1'b0;
      tick();                                            // T+2
      tick();                                            // T+3 (SETTLE)
      check_eq("ab_active_settle", 32'(laneActive_o), 32'h0000_0001);
      #2;
      reset = 1'b0;
      #1;
      check_eq("ab_rst_active", 32'(laneActive_o), 32'h0000_000F);
      check_eq("ab_rst_stall", 32'(issueStall_o), 32'h0);
      check_eq("ab_rst_err", 32'(protocolErr_o), 32'h0);
      #3;
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("ab_no_ack", {28'h0, cfgAck_o, issueStall_o, 2'b00}, 32'h0);
         check_eq("ab_active_hold", 32'(laneActive_o), 32'h0000_000F);
      end

      // Overflow: lane 0 holds at most PIPE_DEPTH+1 = 4
      issueValid_i = 4'b0001;
      for (int i = 0; i < 4; i++) tick();
      check_eq("of_no_err_at_max", 32'(protocolErr_o), 32'h0);
      tick();
      issueValid_i = 4'b0000;
      check_eq("of_err_set", 32'(protocolErr_o), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
      $finish;
   end

endmodule

// File: doc/exec_lane_config_ctrl.md
Name: exec_lane_config_ctrl

Overview:
Sequences dynamic reconfiguration of the execution lanes; each lane is one ExecutionPipe_SC instance.
- Accepts a requested lane mask and stalls issue into register-read.
- Drains in-flight instructions from every lane, then drives the new per-lane laneActive signals, which feed the clock gaters.
- Waits a fixed settle interval before acknowledging and releasing issue.
- Sits between the issue queue/config interface and the execution pipes.

Parameters:
- ISSUE_WIDTH, 4, number of execution lanes.
- PIPE_DEPTH, 3, maximum in-flight instructions per lane (RR, RR/EXE latch, EXE/WB).
- SETTLE_CYCLES, 2, cycles held after a mask change before ack; must be >= 1.
- CNT_W, $clog2(PIPE_DEPTH+2), width of the per-lane in-flight counter.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- flush_i  in  1  recoverFlag | exceptionFlag; squashes all in-flight work.
- cfgReq_i  in  1  reconfiguration request, sampled only in IDLE.
- cfgLaneMask_i  in  ISSUE_WIDTH  requested active lanes; bit0 is forced to 1.
- issueValid_i  in  ISSUE_WIDTH  per-lane instruction entering register-read this cycle.
- wbValid_i  in  ISSUE_WIDTH  per-lane valid ctrlPacket leaving writeback this cycle.
- laneActive_o  out  ISSUE_WIDTH  registered lane enable to the pipes and clock gaters.
- laneIssueEn_o  out  ISSUE_WIDTH  laneActive_o & ~issueStall_o, sent to issue select.
- issueStall_o  out  1  blocks all issue; high in every non-IDLE state.
- cfgBusy_o  out  1  high from the cycle after acceptance until ack.
- cfgAck_o  out  1  one-cycle pulse on completion.
- protocolErr_o  out  1  sticky; set on counter underflow or overflow.

Behaviour:
Reset (asynchronous, active-low):
- State = IDLE, all counters 0, laneActive_o = all ones.
- issueStall_o, cfgBusy_o, cfgAck_o and protocolErr_o are all 0.
- Reset asserted in the middle of a sequence aborts it. No ack is issued.

Per-lane in-flight counter:
- inc = issueValid_i[i], dec = wbValid_i[i].
- inc and dec in the same cycle: counter unchanged.
- flush_i clears every counter to 0 and overrides inc/dec in that cycle.
- dec when count is 0: count stays 0 and protocolErr_o is set.
- inc when count is PIPE_DEPTH+1: count holds and protocolErr_o is set.
- protocolErr_o clears only on reset.

State machine (state register updates on clk):
- IDLE: accept when cfgReq_i = 1. Latch newMask = cfgLaneMask_i | 1.
  - If newMask == laneActive_o, go to ACK (cycle T+1 holds the ack pulse).
  - Otherwise go to DRAIN.
  - cfgReq_i in any other state is ignored; the requester must hold or retry.
- DRAIN: go to APPLY when all counters are 0 in the current cycle, counting updates.
  - Includes the cycle in which flush_i zeroes them.
  - Issue that arrived in the acceptance cycle is still counted.
- APPLY: load laneActive_o <= newMask. Go to SETTLE with the settle counter = SETTLE_CYCLES-1.
- SETTLE: decrement the settle counter; go to ACK when it reaches 0.
- ACK: cfgAck_o = 1 for exactly one cycle, then return to IDLE.

Output rules:
- issueStall_o = (state != IDLE); cfgBusy_o is the same signal.
- Minimum latency from request to ack with a mask change and empty lanes: T+1 DRAIN, T+2 APPLY, T+3 first SETTLE, ack at T+3+SETTLE_CYCLES (T+5 with the defaults).
- issueValid_i asserted on a lane whose laneActive_o = 0, or while stalled, sets protocolErr_o. The counter still updates.

Decomposition:
- Package exec_cfg_pkg holds:
  - the state enum typedef (IDLE, DRAIN, APPLY, SETTLE, ACK);
  - the lane mask typedef;
  - the LANE0_ALWAYS_ON constant.
- Sub-module lane_inflight_counter:
  - one instance per lane via generate;
  - ports: inc, dec, flush, count, err.
- The top level holds the FSM, the settle counter and the mask registers.

Test Plan:
- Reset release: laneActive_o = 4'b1111, all other outputs 0. No further change over 10 idle cycles.
- Simple reconfig: lanes empty, cfgReq_i with mask 4'b0011 at T → issueStall_o high from T+1; laneActive_o = 4'b0011 at T+3; cfgAck_o pulses at T+5; stall low at T+5+1.
- Drain wait: issue one instruction on lane 2 at T, apply the request at T, and assert wbValid_i[2] at T+3 → APPLY at T+4; laneActive_o changes at T+5; ack at T+7.
- Flush during drain: lane 1 count = 2 and flush_i at T+2 → counters 0 and APPLY at T+3. No protocolErr_o.
- Same mask and lane0 forcing: request 4'b1110 while active = 4'b1111 → newMask = 4'b1111, ack at T+1, laneActive_o unchanged.
- Errors and abort: wbValid_i[3] with count 0 → protocolErr_o stays set. Assert reset in SETTLE → IDLE, mask = 4'b1111, no ack.
